csel_adder_pipe: RTL and testbench



---
 rtl/csel_adder_pipe_if.sv | 36 +++
 rtl/csel_adder_pipe.sv | 153 +++++++++++++++
 tb/tb_csel_adder_pipe.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csel_adder_pipe_if.sv
// Handshake/operand bundle for csel_adder_pipe.
// Port sat exists only when CSEL_ADDER_SAT_EN is defined.
interface csel_adder_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
`ifdef CSEL_ADDER_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef CSEL_ADDER_SAT_EN
        output sat,
`endif
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef CSEL_ADDER_SAT_EN
        input  sat,
`endif
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready backpressure.
// Define CSEL_ADDER_SAT_EN to add the saturating-result option (port sat).
module csel_adder_pipe #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned BLK         = 4,
    parameter int unsigned PIPE_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    csel_adder_pipe_if.slave bus
);
    localparam int unsigned NBLK = WIDTH / BLK;
    localparam int unsigned GRP  = NBLK / PIPE_STAGES;
    localparam int unsigned NMID = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
    localparam int unsigned LAST = PIPE_STAGES - 1;

    // Intermediate stage registers; the final stage is held in r_sum/r_cout/r_ovf
    logic [WIDTH-1:0]       r_a [NMID];
    logic [WIDTH-1:0]       r_b [NMID];
    logic [WIDTH-1:0]       r_s [NMID];
    logic [NMID-1:0]        r_c;
    logic [PIPE_STAGES-1:0] r_v;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_cout;
    logic                   r_ovf;

    logic [WIDTH-1:0]       w_b_eff;
    logic                   w_c_eff;
    logic [WIDTH-1:0]       w_in_a  [PIPE_STAGES];
    logic [WIDTH-1:0]       w_in_b  [PIPE_STAGES];
    logic [WIDTH-1:0]       w_in_s  [PIPE_STAGES];
    logic [WIDTH-1:0]       w_out_s [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] w_in_c;
    logic [PIPE_STAGES-1:0] w_out_c;
    logic [PIPE_STAGES-1:0] w_in_v;
    logic [PIPE_STAGES-1:0] w_adv;
    logic [BLK:0]           w_r0;
    logic [BLK:0]           w_r1;
    logic [BLK:0]           w_r;
    logic                   w_c;
    logic                   w_full;
    logic                   w_ovf;
    logic [WIDTH-1:0]       w_sum_fin;

`ifdef CSEL_ADDER_SAT_EN
    logic [NMID-1:0]        r_sat;
    logic [PIPE_STAGES-1:0] w_in_sat;
`endif

    always_comb begin
        w_b_eff   = bus.b ^ {WIDTH{bus.sub}};
        w_c_eff   = bus.cin ^ bus.sub;
        w_in_a[0] = bus.a;
        w_in_b[0] = w_b_eff;
        w_in_s[0] = '0;
        w_in_c[0] = w_c_eff;
        w_in_v[0] = bus.in_valid;
`ifdef CSEL_ADDER_SAT_EN
        w_in_sat[0] = bus.sat;
`endif
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            w_in_a[s] = r_a[s-1];
            w_in_b[s] = r_b[s-1];
            w_in_s[s] = r_s[s-1];
            w_in_c[s] = r_c[s-1];
            w_in_v[s] = r_v[s-1];
`ifdef CSEL_ADDER_SAT_EN
            w_in_sat[s] = r_sat[s-1];
`endif
        end

        // Each stage resolves its own group of blocks; block 0 ripples with c_eff
        w_r0 = '0;
        w_r1 = '0;
        w_r  = '0;
        w_c  = 1'b0;
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            w_out_s[s] = w_in_s[s];
            w_c        = w_in_c[s];
            for (int unsigned k = 0; k < GRP; k++) begin
                w_r0 = {1'b0, w_in_a[s][(s*GRP+k)*BLK +: BLK]}
                     + {1'b0, w_in_b[s][(s*GRP+k)*BLK +: BLK]};
                w_r1 = w_r0 + {{BLK{1'b0}}, 1'b1};
                if ((s * GRP + k) == 0) begin
                    w_r = w_r0 + {{BLK{1'b0}}, w_c};
                end else begin
                    w_r = w_c ? w_r1 : w_r0;
                end
                w_out_s[s][(s*GRP+k)*BLK +: BLK] = w_r[BLK-1:0];
                w_c = w_r[BLK];
            end
            w_out_c[s] = w_c;
        end

        // adv[s] = !v[s] || adv[s+1], unrolled so no bit depends on another bit
        w_full = 1'b1;
        w_adv  = '0;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            w_full   = w_full & r_v[s];
            w_adv[s] = bus.out_ready || !w_full;
        end

        w_ovf = (w_in_a[LAST][WIDTH-1] == w_in_b[LAST][WIDTH-1])
             && (w_out_s[LAST][WIDTH-1] != w_in_a[LAST][WIDTH-1]);
`ifdef CSEL_ADDER_SAT_EN
        if (w_in_sat[LAST] && w_ovf) begin
            w_sum_fin = {w_in_a[LAST][WIDTH-1], {(WIDTH-1){~w_in_a[LAST][WIDTH-1]}}};
        end else begin
            w_sum_fin = w_out_s[LAST];
        end
`else
        w_sum_fin = w_out_s[LAST];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < LAST; s++) begin
                if (w_adv[s]) begin
                    r_v[s] <= w_in_v[s];
                    if (w_in_v[s]) begin
                        r_a[s] <= w_in_a[s];
                        r_b[s] <= w_in_b[s];
                        r_s[s] <= w_out_s[s];
                        r_c[s] <= w_out_c[s];
`ifdef CSEL_ADDER_SAT_EN
                        r_sat[s] <= w_in_sat[s];
`endif
                    end
                end
            end
            if (w_adv[LAST]) begin
                r_v[LAST] <= w_in_v[LAST];
                if (w_in_v[LAST]) begin
                    r_sum  <= w_sum_fin;
                    r_cout <= w_out_c[LAST];
                    r_ovf  <= w_ovf;
                end
            end
        end
    end

    assign bus.in_ready  = rst || w_adv[0];
    assign bus.out_valid = r_v[LAST];
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe: directed cases on a 32/4/2 instance,
// randomized traffic on 32/4/2 and 64/8/4 instances against an arithmetic model.
module tb_csel_adder_pipe;
    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 1;
    int   bp_cyc = 0;
    bit   saw_stall = 0;
    exp_t q0[$];
    exp_t q1[$];

    csel_adder_pipe_if #(.WIDTH(32)) bus0 ();
    csel_adder_pipe_if #(.WIDTH(64)) bus1 ();

    csel_adder_pipe #(.WIDTH(32), .BLK(4), .PIPE_STAGES(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    csel_adder_pipe #(.WIDTH(64), .BLK(8), .PIPE_STAGES(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input int unsigned w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain wide-integer arithmetic on the conditioned operands
    function automatic exp_t model(input int unsigned w, input logic [63:0] a,
                                   input logic [63:0] b, input logic cin,
                                   input logic sub, input logic sat);
        exp_t r;
        logic [63:0] mask, am, be;
        logic [64:0] u;
        logic signed [66:0] sa, sb, ss, smax, smin, one;
        logic ce;
        mask   = mask_of(w);
        am     = a & mask;
        be     = (sub ? ~b : b) & mask;
        ce     = cin ^ sub;
        u      = {1'b0, am} + {1'b0, be} + {64'd0, ce};
        r.sum  = u[63:0] & mask;
        r.cout = u[w];
        one    = 67'sd1;
        sa     = $signed({3'b000, am}) - (am[w-1] ? (one <<< w) : 67'sd0);
        sb     = $signed({3'b000, be}) - (be[w-1] ? (one <<< w) : 67'sd0);
        ss     = sa + sb + $signed({66'd0, ce});
        smax   = (one <<< (w - 1)) - one;
        smin   = -(one <<< (w - 1));
        r.ovf  = (ss > smax) || (ss < smin);
        if (sat && r.ovf) r.sum = ((ss > smax) ? smax[63:0] : smin[63:0]) & mask;
        return r;
    endfunction

    function automatic logic [63:0] rndw(input int unsigned w);
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0:       v = '1;
            1:       v = 64'd1 << (w - 1);
            2:       v = (64'd1 << (w - 1)) - 64'd1;
            3:       v = '0;
            default: v = {$urandom, $urandom};
        endcase
        return v & mask_of(w);
    endfunction

    // out_ready driver for dut0: 0 low, 1 high, 2 backpressure window, 3 random
    initial begin
        bus0.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bp_cyc++;
            case (rdy_mode)
                0:       bus0.out_ready = 1'b0;
                1:       bus0.out_ready = 1'b1;
                2:       bus0.out_ready = !(bp_cyc >= 3 && bp_cyc <= 5);
                default: bus0.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus0.out_valid) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d0 spurious got sum=%h required=no output", bus0.sum);
                end else begin
                    e = q0[0];
                    chk("d0 sum", 64'(bus0.sum), e.sum);
                    chk("d0 cout", 64'(bus0.cout), 64'(e.cout));
                    chk("d0 ovf", 64'(bus0.ovf), 64'(e.ovf));
                    if (bus0.out_ready) void'(q0.pop_front());
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus1.out_valid) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d1 spurious got sum=%h required=no output", bus1.sum);
                end else begin
                    e = q1[0];
                    chk("d1 sum", bus1.sum, e.sum);
                    chk("d1 cout", 64'(bus1.cout), 64'(e.cout));
                    chk("d1 ovf", 64'(bus1.ovf), 64'(e.ovf));
                    if (bus1.out_ready) void'(q1.pop_front());
                end
            end
        end
    end

    // Called and returns at posedge+#1; holds the op until accepted
    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input logic sat, input exp_t e);
        int n = 0;
        bit done = 0;
        bus0.in_valid = 1'b1;
        bus0.a        = a;
        bus0.b        = b;
        bus0.cin      = cin;
        bus0.sub      = sub;
`ifdef CSEL_ADDER_SAT_EN
        bus0.sat      = sat;
`else
        if (sat) $display("note: sat ignored in this build");
`endif
        while (!done) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                q0.push_back(e);
                done = 1;
            end else begin
                saw_stall = 1;
                n++;
                if (n >= 50) begin
                    checks++;
                    errors++;
                    $display("FAIL d0 accept timeout got=in_ready 0 required=1");
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus0.in_valid = 1'b0;
    endtask

    task automatic wait_empty0();
        int n = 0;
        while (q0.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL d0 drain got=%0d pending required=0", q0.size());
        end
    endtask

    task automatic rand0(input int n);
        int sent = 0;
        int cyc = 0;
        logic [63:0] a, b;
        logic cin, sub, sat;
        while (sent < n && cyc < 60000) begin
            a   = rndw(32);
            b   = rndw(32);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
`ifdef CSEL_ADDER_SAT_EN
            sat = 1'($urandom_range(0, 1));
            bus0.sat = sat;
`else
            sat = 1'b0;
`endif
            bus0.in_valid = ($urandom_range(0, 3) != 0);
            bus0.a   = a[31:0];
            bus0.b   = b[31:0];
            bus0.cin = cin;
            bus0.sub = sub;
            @(negedge clk);
            if (bus0.in_valid && bus0.in_ready) begin
                q0.push_back(model(32, a, b, cin, sub, sat));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus0.in_valid = 1'b0;
        chk("d0 random ops issued", 64'(sent), 64'(n));
    endtask

    task automatic rand1(input int n);
        int sent = 0;
        int cyc = 0;
        logic [63:0] a, b;
        logic cin, sub, sat;
        while (sent < n && cyc < 60000) begin
            a   = rndw(64);
            b   = rndw(64);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
`ifdef CSEL_ADDER_SAT_EN
            sat = 1'($urandom_range(0, 1));
            bus1.sat = sat;
`else
            sat = 1'b0;
`endif
            bus1.in_valid  = ($urandom_range(0, 3) != 0);
            bus1.out_ready = ($urandom_range(0, 3) != 0);
            bus1.a   = a;
            bus1.b   = b;
            bus1.cin = cin;
            bus1.sub = sub;
            @(negedge clk);
            if (bus1.in_valid && bus1.in_ready) begin
                q1.push_back(model(64, a, b, cin, sub, sat));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        chk("d1 random ops issued", 64'(sent), 64'(n));
    endtask

    initial begin
        exp_t e;
        int n;
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        bus0.a = '0;
        bus0.b = '0;
        bus0.cin = 1'b0;
        bus0.sub = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        bus1.a = '0;
        bus1.b = '0;
        bus1.cin = 1'b0;
        bus1.sub = 1'b0;
`ifdef CSEL_ADDER_SAT_EN
        bus0.sat = 1'b0;
        bus1.sat = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 64'(bus0.in_ready), 64'd1);
        chk("rst out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst sum", 64'(bus0.sum), 64'd0);
        chk("rst cout", 64'(bus0.cout), 64'd0);
        chk("rst ovf", 64'(bus0.ovf), 64'd0);
        chk("rst d1 out_valid", 64'(bus1.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Wrap to zero with carry-out, plus one-cycle latency
        e = '{sum: 64'h0, cout: 1'b1, ovf: 1'b0};
        send0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, e);
        chk("lat capture out_valid", 64'(bus0.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat +1 out_valid", 64'(bus0.out_valid), 64'd1);
        wait_empty0();

        e = '{sum: 64'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0};
        send0(32'h5, 32'h7, 1'b0, 1'b1, 1'b0, e);
        e = '{sum: 64'hFFFF_FFFD, cout: 1'b0, ovf: 1'b0};
        send0(32'h5, 32'h7, 1'b1, 1'b1, 1'b0, e);
        e = '{sum: 64'h8000_0000, cout: 1'b0, ovf: 1'b1};
        send0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, e);
        e = '{sum: 64'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1};
        send0(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0, e);
`ifdef CSEL_ADDER_SAT_EN
        e = '{sum: 64'h7FFF_FFFF, cout: 1'b0, ovf: 1'b1};
        send0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, e);
        e = '{sum: 64'h8000_0000, cout: 1'b1, ovf: 1'b1};
        send0(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, e);
`endif
        wait_empty0();

        // Back-to-back stream with out_ready low for a few cycles
        saw_stall = 0;
        rdy_mode = 2;
        bp_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            e = '{sum: 64'(4 * i), cout: 1'b0, ovf: 1'b0};
            send0(32'(i), 32'(i * 3), 1'b0, 1'b0, 1'b0, e);
        end
        wait_empty0();
        chk("bp in_ready dropped", 64'(saw_stall), 64'd1);
        rdy_mode = 1;

        // Reset with two results in flight
        rdy_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        e = '{sum: 64'h2, cout: 1'b0, ovf: 1'b0};
        send0(32'h1, 32'h1, 1'b0, 1'b0, 1'b0, e);
        e = '{sum: 64'h4, cout: 1'b0, ovf: 1'b0};
        send0(32'h2, 32'h2, 1'b0, 1'b0, 1'b0, e);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst in_ready", 64'(bus0.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        chk("post rst out_valid", 64'(bus0.out_valid), 64'd0);
        chk("post rst sum", 64'(bus0.sum), 64'd0);
        rdy_mode = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        e = '{sum: 64'h7, cout: 1'b0, ovf: 1'b0};
        send0(32'h3, 32'h4, 1'b0, 1'b0, 1'b0, e);
        wait_empty0();

        // Randomized traffic on both instances
        rdy_mode = 3;
        fork
            rand0(10000);
            rand1(10000);
        join
        rdy_mode = 1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("final d0 pending", 64'(q0.size()), 64'd0);
        chk("final d1 pending", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
